alu_iter: RTL and testbench

Parametrised, multi-cycle successor to the 8-bit combinational ALU. It operates on WIDTH-bit operands. Single-cycle ops (AND, XOR, ADD, SUB) finish in one clock. Shifts run one bit per clock, and multiply runs iteratively by shift-add. A START/BUSY/DONE handshake lets the core controller stall on long ops, and the block registers the result and the CARRY/ZF flags for the branch and datapath logic.

---
 rtl/alu_iter_if.sv | 26 ++
 rtl/alu_iter.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_iter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_if.sv
// alu_iter_if: START/BUSY/DONE handshake and operand/result bundle for alu_iter.
//   master : drives start, op, r1, r2; observes busy, done, out, carry, zf
//   slave  : the ALU side of the same signals
interface alu_iter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zf;

  modport master (
    output start, op, r1, r2,
    input  busy, done, out, carry, zf
  );

  modport slave (
    input  start, op, r1, r2,
    output busy, done, out, carry, zf
  );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle WIDTH-bit ALU.
//   AND/XOR/ADD/SUB/reserved complete in one EXEC cycle, shifts take one
//   cycle per bit, and MUL is an iterative shift-add over WIDTH cycles.
//   Results and CARRY/ZF flags are registered and held until the next completion.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset; aborts any op in flight
//   bus  - alu_iter_if.slave (start/op/r1/r2 in; busy/done/out/carry/zf out)
// Build option:
//   ALU_ITER_MUL_EN - when defined, OP 110 is the iterative multiplier; when
//                     undefined, the multiplier is absent and OP 110 acts as reserved.
//
// state  | meaning
// S_IDLE | waiting for start; busy=0 (includes the done cycle)
// S_EXEC | operation in progress; busy=1, start ignored
module alu_iter #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
`ifdef ALU_ITER_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;
`endif

  typedef enum logic {
    S_IDLE,
    S_EXEC
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             zf_q, zf_d;
  logic             done_q, done_d;

`ifdef ALU_ITER_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
`endif

  logic             fin;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [WIDTH:0]   add_w;
  logic [CW-1:0]    n_acc;
  logic [WIDTH-1:0] sh_val;
  logic             sh_bit;

  // Shift amount saturates at WIDTH: shifting further cannot change the result.
  always_comb begin
    if (bus.r1 >= WIDTH'(WIDTH)) n_acc = CW'(WIDTH);
    else                         n_acc = CW'(bus.r1);
  end

  // One-bit shift step on the held value; sh_bit is the bit falling off the end.
  always_comb begin
    if (op_q == OP_SHL) begin
      sh_val = {b_q[WIDTH-2:0], 1'b0};
      sh_bit = b_q[WIDTH-1];
    end else begin
      sh_val = {1'b0, b_q[WIDTH-1:1]};
      sh_bit = b_q[0];
    end
  end

`ifdef ALU_ITER_MUL_EN
  // Multiplier sits in the low half of acc and is consumed LSB first while the
  // partial product accumulates in the high half; after WIDTH steps acc holds R1*R2.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    carry_d = carry_q;
    zf_d    = zf_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    res     = '0;
    res_c   = 1'b0;
    add_w   = '0;
`ifdef ALU_ITER_MUL_EN
    acc_d   = acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_EXEC;
          op_d    = bus.op;
          a_d     = bus.r1;
          b_d     = bus.r2;
          cnt_d   = n_acc;
`ifdef ALU_ITER_MUL_EN
          if (bus.op == OP_MUL) cnt_d = CW'(WIDTH);
          acc_d = {{WIDTH{1'b0}}, bus.r1};
`endif
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_AND: begin
            fin = 1'b1;
            res = a_q & b_q;
          end
          OP_XOR: begin
            fin = 1'b1;
            res = a_q ^ b_q;
          end
          OP_ADD: begin
            fin   = 1'b1;
            add_w = {1'b0, b_q} + {1'b0, a_q};
            res   = add_w[WIDTH-1:0];
            res_c = add_w[WIDTH];
          end
          OP_SUB: begin
            // Bit WIDTH of the extended difference is the borrow (R1 > R2).
            fin   = 1'b1;
            add_w = {1'b0, b_q} - {1'b0, a_q};
            res   = add_w[WIDTH-1:0];
            res_c = add_w[WIDTH];
          end
          OP_SHL, OP_SHR: begin
            if (cnt_q == '0) begin
              fin = 1'b1;
              res = b_q;
            end else begin
              b_d   = sh_val;
              cnt_d = cnt_q - CW'(1);
              if (cnt_q == CW'(1)) begin
                fin   = 1'b1;
                res   = sh_val;
                res_c = sh_bit;
              end
            end
          end
`ifdef ALU_ITER_MUL_EN
          OP_MUL: begin
            acc_d = acc_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              fin   = 1'b1;
              res   = acc_step[WIDTH-1:0];
              res_c = |acc_step[2*WIDTH-1:WIDTH];
            end
          end
`endif
          default: begin
            fin = 1'b1;
            res = '0;
          end
        endcase

        if (fin) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          out_d   = res;
          carry_d = res_c;
          zf_d    = (res == '0);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zf_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_ITER_MUL_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zf_q    <= zf_d;
      done_q  <= done_d;
`ifdef ALU_ITER_MUL_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign bus.busy  = (state_q == S_EXEC);
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign bus.carry = carry_q;
  assign bus.zf    = zf_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: self-checking bench for alu_iter at WIDTH=8 and WIDTH=16.
// Directed vector table, randomized ops against a reference model, and
// hand-written handshake/reset sequences. ALU_ITER_MUL_EN selects MUL expectations.
module tb_alu_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_iter_if #(.WIDTH(8))  i8 ();
  alu_iter_if #(.WIDTH(16)) i16 ();

  alu_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
  alu_iter #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] eo;
    logic       ec;
    logic       ez;
    logic [7:0] el;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: result straight from the opcode definitions with wide arithmetic.
  function automatic void model(input longint unsigned w, input int op,
                                input longint unsigned r1, input longint unsigned r2,
                                output longint unsigned o, output logic c, output int lat);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned n    = (r1 < w) ? r1 : w;
    longint unsigned p;
    o = 0; c = 1'b0; lat = 1;
    case (op)
      0: o = r1 & r2;
      1: o = r1 ^ r2;
      2: begin
        o   = (r2 << n) & mask;
        c   = (n == 0) ? 1'b0 : 1'((r2 >> (w - n)) & 64'd1);
        lat = (n == 0) ? 1 : int'(n);
      end
      3: begin
        o   = r2 >> n;
        c   = (n == 0) ? 1'b0 : 1'((r2 >> (n - 64'd1)) & 64'd1);
        lat = (n == 0) ? 1 : int'(n);
      end
      4: begin
        p = r1 + r2;
        o = p & mask;
        c = 1'((p >> w) & 64'd1);
      end
      5: begin
        o = (r2 - r1) & mask;
        c = (r1 > r2);
      end
`ifdef ALU_ITER_MUL_EN
      6: begin
        p   = r1 * r2;
        o   = p & mask;
        c   = ((p >> w) != 0);
        lat = int'(w);
      end
`endif
      default: begin
        o = 0;
        c = 1'b0;
      end
    endcase
  endfunction

  task automatic run8(input string nm, input logic [2:0] op, input logic [7:0] r1,
                      input logic [7:0] r2, input logic [7:0] eo, input logic ec,
                      input logic ez, input int el);
    int  bcnt = 0;
    bit  got  = 0;
    @(negedge clk);
    i8.start = 1'b1; i8.op = op; i8.r1 = r1; i8.r2 = r2;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the latched operands must be used.
    i8.start = 1'b0; i8.op = 3'($urandom); i8.r1 = 8'($urandom); i8.r2 = 8'($urandom);
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge clk);
      if (i8.done) got = 1;
      else if (i8.busy) bcnt++;
    end
    chk({nm, " done_seen"}, got, 1);
    if (got) begin
      chk({nm, " latency"}, bcnt, el);
      chk({nm, " busy_in_done"}, i8.busy, 0);
      chk({nm, " out"}, i8.out, eo);
      chk({nm, " carry"}, i8.carry, ec);
      chk({nm, " zf"}, i8.zf, ez);
    end
    @(negedge clk);
    chk({nm, " done_pulse_width"}, i8.done, 0);
    chk({nm, " out_held"}, i8.out, eo);
  endtask

  task automatic run16(input string nm, input logic [2:0] op, input logic [15:0] r1,
                       input logic [15:0] r2, input logic [15:0] eo, input logic ec,
                       input logic ez, input int el);
    int  bcnt = 0;
    bit  got  = 0;
    @(negedge clk);
    i16.start = 1'b1; i16.op = op; i16.r1 = r1; i16.r2 = r2;
    @(posedge clk);
    #1;
    i16.start = 1'b0; i16.r1 = 16'($urandom); i16.r2 = 16'($urandom);
    for (int cyc = 0; cyc < 60 && !got; cyc++) begin
      @(negedge clk);
      if (i16.done) got = 1;
      else if (i16.busy) bcnt++;
    end
    chk({nm, " done_seen"}, got, 1);
    if (got) begin
      chk({nm, " latency"}, bcnt, el);
      chk({nm, " out"}, i16.out, eo);
      chk({nm, " carry"}, i16.carry, ec);
      chk({nm, " zf"}, i16.zf, ez);
    end
    @(negedge clk);
    chk({nm, " done_pulse_width"}, i16.done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint unsigned mo;
    logic            mc;
    int              ml;
    logic [2:0]      rop;
    logic [7:0]      ra, rb;
    int              dcnt;
    bit              got;

    tbl[0]  = '{3'd4, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 8'd1};  // ADD wrap
    tbl[1]  = '{3'd5, 8'h05, 8'h03, 8'hFE, 1'b1, 1'b0, 8'd1};  // SUB borrow
    tbl[2]  = '{3'd2, 8'h03, 8'hB1, 8'h88, 1'b1, 1'b0, 8'd3};  // SHL 3
    tbl[3]  = '{3'd3, 8'h09, 8'h81, 8'h00, 1'b1, 1'b1, 8'd8};  // SHR saturated
    tbl[4]  = '{3'd3, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'd1};  // SHR by 0
`ifdef ALU_ITER_MUL_EN
    tbl[5]  = '{3'd6, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 8'd8};  // MUL overflow
`else
    tbl[5]  = '{3'd6, 8'h10, 8'h11, 8'h00, 1'b0, 1'b1, 8'd1};  // MUL as reserved
`endif
    tbl[6]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 8'd1};  // AND
    tbl[7]  = '{3'd1, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 8'd1};  // XOR to zero
    tbl[8]  = '{3'd7, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 8'd1};  // reserved
    tbl[9]  = '{3'd2, 8'h08, 8'h01, 8'h00, 1'b1, 1'b1, 8'd8};  // SHL by WIDTH
    tbl[10] = '{3'd2, 8'h01, 8'h80, 8'h00, 1'b1, 1'b1, 8'd1};  // SHL by 1
    tbl[11] = '{3'd4, 8'h80, 8'h7F, 8'hFF, 1'b0, 1'b0, 8'd1};  // ADD no carry

    i8.start = 1'b0;  i8.op = '0;  i8.r1 = '0;  i8.r2 = '0;
    i16.start = 1'b0; i16.op = '0; i16.r1 = '0; i16.r2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset busy",  i8.busy,  0);
    chk("reset done",  i8.done,  0);
    chk("reset out",   i8.out,   0);
    chk("reset carry", i8.carry, 0);
    chk("reset zf",    i8.zf,    0);
    chk("reset16 out", i16.out,  0);

    for (int i = 0; i < 12; i++)
      run8($sformatf("vec%0d", i), tbl[i].op, tbl[i].r1, tbl[i].r2,
           tbl[i].eo, tbl[i].ec, tbl[i].ez, int'(tbl[i].el));

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = (rop == 3'd2 || rop == 3'd3) ? 8'($urandom_range(0, 11)) : 8'($urandom);
      rb  = 8'($urandom);
      model(64'd8, int'(rop), 64'(ra), 64'(rb), mo, mc, ml);
      run8($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, 8'(mo), mc, (mo == 0), ml);
    end

    // START during a long op is dropped; original result delivered, no second DONE.
    @(negedge clk);
    i8.start = 1'b1;
`ifdef ALU_ITER_MUL_EN
    i8.op = 3'd6; i8.r1 = 8'h10; i8.r2 = 8'h11;
`else
    i8.op = 3'd3; i8.r1 = 8'h06; i8.r2 = 8'hC0;
`endif
    @(negedge clk);
    i8.start = 1'b0;
    @(negedge clk);
    i8.start = 1'b1; i8.op = 3'd4; i8.r1 = 8'h01; i8.r2 = 8'h02;
    @(negedge clk);
    i8.start = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (i8.done) got = 1;
    end
    chk("ignore_start done_seen", got, 1);
`ifdef ALU_ITER_MUL_EN
    chk("ignore_start out",   i8.out,   8'h10);
    chk("ignore_start carry", i8.carry, 1);
`else
    chk("ignore_start out",   i8.out,   8'h03);
    chk("ignore_start carry", i8.carry, 0);
`endif
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (i8.done || i8.busy) dcnt++;
    end
    chk("ignore_start no_extra_op", dcnt, 0);

    // START held high through the DONE cycle: second op accepted there.
    @(negedge clk);
    i8.start = 1'b1; i8.op = 3'd4; i8.r1 = 8'h01; i8.r2 = 8'h02;
    @(negedge clk);
    chk("b2b first busy", i8.busy, 1);
    i8.op = 3'd1; i8.r1 = 8'h0F; i8.r2 = 8'hF0;
    @(negedge clk);
    chk("b2b first done", i8.done, 1);
    chk("b2b first busy_low", i8.busy, 0);
    chk("b2b first out", i8.out, 8'h03);
    @(negedge clk);
    chk("b2b second busy", i8.busy, 1);
    chk("b2b second done_low", i8.done, 0);
    i8.start = 1'b0;
    @(negedge clk);
    chk("b2b second done", i8.done, 1);
    chk("b2b second out", i8.out, 8'hFF);
    @(negedge clk);
    chk("b2b idle", i8.busy, 0);

    // Reset mid-shift: everything cleared, no DONE afterwards.
    run8("pre_reset add", 3'd4, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1);
    @(negedge clk);
    i8.start = 1'b1; i8.op = 3'd2; i8.r1 = 8'h05; i8.r2 = 8'h01;
    @(negedge clk);
    i8.start = 1'b0;
    @(negedge clk);
    chk("rst_mid busy_before", i8.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid busy",  i8.busy,  0);
    chk("rst_mid done",  i8.done,  0);
    chk("rst_mid out",   i8.out,   0);
    chk("rst_mid carry", i8.carry, 0);
    chk("rst_mid zf",    i8.zf,    0);
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (i8.done) dcnt++;
    end
    chk("rst_mid no_done", dcnt, 0);

    // WIDTH=16 instance.
    run16("w16 add", 3'd4, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1);
`ifdef ALU_ITER_MUL_EN
    run16("w16 mul", 3'd6, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 16);
`else
    run16("w16 mul", 3'd6, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 1);
`endif
    run16("w16 shr", 3'd3, 16'h0004, 16'h8F00, 16'h08F0, 1'b0, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
